// File: rtl/reset_sequencer.sv
// Board-level reset controller: qualifies PLL locks, a debounced button and a software
// request, then releases staged resets in order and records the cause of the last reset.
module reset_sequencer #(
    parameter int NUM_LOCKS          = 2,
    parameter int NUM_STAGES         = 3,
    parameter int STAGE_DELAY_CYCLES = 1024,
    parameter int DEBOUNCE_CYCLES    = 400_000,
    parameter int SYNC_STAGES        = 2
) (
    input  logic                  clk,
    input  logic                  reset_n_i,
    input  logic [NUM_LOCKS-1:0]  locked_i,
    input  logic                  btn_reset_n_i,
    input  logic                  sw_reset_i,
    output logic [NUM_STAGES-1:0] reset_o,
    output logic                  all_ready_o,
    output logic [1:0]            cause_o
);

    localparam int CW = $clog2(STAGE_DELAY_CYCLES) + 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int SW = $clog2(NUM_STAGES) + 1;

    localparam logic [CW-1:0]         CNT_LAST = CW'(STAGE_DELAY_CYCLES - 1);
    localparam logic [DW-1:0]         DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0]         STG_LAST = SW'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] ALL_SET  = {NUM_STAGES{1'b1}};

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_LOCK = 2'b01;
    localparam logic [1:0] CAUSE_BTN  = 2'b10;
    localparam logic [1:0] CAUSE_SW   = 2'b11;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STAGGER = 2'd1,
        RUN     = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0][NUM_LOCKS-1:0] lock_sync_r;
    logic [SYNC_STAGES-1:0]                btn_sync_r;
    logic [SYNC_STAGES-1:0]                sw_sync_r;
    logic                                  sw_prev_r;
    logic [DW-1:0]                         deb_cnt_r;
    logic                                  btn_deb_r;

    state_t                                state_r;
    logic [CW-1:0]                         cnt_r;
    logic [SW-1:0]                         stg_r;
    logic [NUM_STAGES-1:0]                 reset_r;
    logic                                  all_ready_r;
    logic [1:0]                            cause_r;

    logic                                  lock_ok_s;
    logic                                  btn_sync_s;
    logic                                  sw_sync_s;
    logic                                  sw_req_s;
    logic                                  btn_pressed_s;
    logic                                  stagger_fault_s;
    logic                                  run_fault_s;
    logic [1:0]                            fault_cause_s;

    // Input synchronisers; the button idles released (high), locks and sw idle low.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lock_sync_r <= {(SYNC_STAGES*NUM_LOCKS){1'b0}};
            btn_sync_r  <= {SYNC_STAGES{1'b1}};
            sw_sync_r   <= {SYNC_STAGES{1'b0}};
            sw_prev_r   <= 1'b0;
        end else begin
            lock_sync_r <= {lock_sync_r[SYNC_STAGES-2:0], locked_i};
            btn_sync_r  <= {btn_sync_r[SYNC_STAGES-2:0], btn_reset_n_i};
            sw_sync_r   <= {sw_sync_r[SYNC_STAGES-2:0], sw_reset_i};
            sw_prev_r   <= sw_sync_s;
        end
    end

    assign lock_ok_s     = &lock_sync_r[SYNC_STAGES-1];
    assign btn_sync_s    = btn_sync_r[SYNC_STAGES-1];
    assign sw_sync_s     = sw_sync_r[SYNC_STAGES-1];
    assign sw_req_s      = sw_sync_s & ~sw_prev_r;
    assign btn_pressed_s = ~btn_deb_r;

    // Button debouncer: adopt the synchronised level after a full run of differing samples.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            deb_cnt_r <= {DW{1'b0}};
            btn_deb_r <= 1'b1;
        end else if (btn_sync_s == btn_deb_r) begin
            deb_cnt_r <= {DW{1'b0}};
        end else if (deb_cnt_r == DEB_LAST) begin
            deb_cnt_r <= {DW{1'b0}};
            btn_deb_r <= btn_sync_s;
        end else begin
            deb_cnt_r <= deb_cnt_r + DW'(1);
        end
    end

    assign stagger_fault_s = ~lock_ok_s | btn_pressed_s;
    assign run_fault_s     = stagger_fault_s | sw_req_s;

    // Fault cause encoding with lock > button > software priority.
    always_comb begin
        fault_cause_s = CAUSE_POR;
        if (!lock_ok_s) begin
            fault_cause_s = CAUSE_LOCK;
        end else if (btn_pressed_s) begin
            fault_cause_s = CAUSE_BTN;
        end else begin
            fault_cause_s = CAUSE_SW;
        end
    end

    // Sequencer FSM with registered reset, ready and cause outputs.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= HOLD;
            cnt_r       <= {CW{1'b0}};
            stg_r       <= {SW{1'b0}};
            reset_r     <= ALL_SET;
            all_ready_r <= 1'b0;
            cause_r     <= CAUSE_POR;
        end else begin
            case (state_r)
                HOLD: begin
                    reset_r     <= ALL_SET;
                    all_ready_r <= 1'b0;
                    if (lock_ok_s && !btn_pressed_s) begin
                        if (cnt_r == CNT_LAST) begin
                            cnt_r   <= {CW{1'b0}};
                            reset_r <= ALL_SET << 1'b1;
                            stg_r   <= SW'(1);
                            if (NUM_STAGES == 1) begin
                                state_r     <= RUN;
                                all_ready_r <= 1'b1;
                            end else begin
                                state_r <= STAGGER;
                            end
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end else begin
                        cnt_r <= {CW{1'b0}};
                    end
                end
                STAGGER: begin
                    if (stagger_fault_s) begin
                        state_r     <= HOLD;
                        cnt_r       <= {CW{1'b0}};
                        stg_r       <= {SW{1'b0}};
                        reset_r     <= ALL_SET;
                        all_ready_r <= 1'b0;
                        cause_r     <= fault_cause_s;
                    end else if (cnt_r == CNT_LAST) begin
                        // Stages release strictly in order, so the vector is a shifted mask.
                        cnt_r   <= {CW{1'b0}};
                        reset_r <= ALL_SET << (stg_r + SW'(1));
                        stg_r   <= stg_r + SW'(1);
                        if (stg_r == STG_LAST) begin
                            state_r     <= RUN;
                            all_ready_r <= 1'b1;
                        end else begin
                            state_r <= STAGGER;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                RUN: begin
                    if (run_fault_s) begin
                        state_r     <= HOLD;
                        cnt_r       <= {CW{1'b0}};
                        stg_r       <= {SW{1'b0}};
                        reset_r     <= ALL_SET;
                        all_ready_r <= 1'b0;
                        cause_r     <= fault_cause_s;
                    end else begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r     <= HOLD;
                    cnt_r       <= {CW{1'b0}};
                    stg_r       <= {SW{1'b0}};
                    reset_r     <= ALL_SET;
                    all_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign reset_o     = reset_r;
    assign all_ready_o = all_ready_r;
    assign cause_o     = cause_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: directed scenarios plus random traffic, expected
// outputs from a release-count reference model queued per cycle and checked by a monitor.
module tb_reset_sequencer;

    localparam int NL  = 2;
    localparam int NS  = 3;
    localparam int D   = 8;
    localparam int DEB = 16;
    localparam int SY  = 2;
    localparam int EW  = NS + 3;

    logic          clk = 1'b0;
    logic          reset_n_i;
    logic [NL-1:0] locked_i;
    logic          btn_reset_n_i;
    logic          sw_reset_i;
    logic [NS-1:0] reset_o;
    logic          all_ready_o;
    logic [1:0]    cause_o;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_LOCKS          (NL),
        .NUM_STAGES         (NS),
        .STAGE_DELAY_CYCLES (D),
        .DEBOUNCE_CYCLES    (DEB),
        .SYNC_STAGES        (SY)
    ) dut (
        .clk           (clk),
        .reset_n_i     (reset_n_i),
        .locked_i      (locked_i),
        .btn_reset_n_i (btn_reset_n_i),
        .sw_reset_i    (sw_reset_i),
        .reset_o       (reset_o),
        .all_ready_o   (all_ready_o),
        .cause_o       (cause_o)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [EW-1:0] exp_q[$];

    // Stimulus levels held between ticks
    logic          cur_rst;
    logic [NL-1:0] cur_lk;
    logic          cur_bt;
    logic          cur_sw;

    // Reference model: input sample histories (index 0 newest), debounce window,
    // number of released stages, gap timer and recorded cause.
    logic [NL-1:0] m_lk  [SY+1];
    logic          m_bt  [SY+1];
    logic          m_sw  [SY+1];
    logic          m_obs [DEB];
    logic          m_deb;
    int            m_rel;
    int            m_t;
    logic [1:0]    m_cause;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s at %0t: got reset=%b ready=%b cause=%b, want reset=%b ready=%b cause=%b",
                         name, $time, act[EW-1:3], act[2], act[1:0], exp[EW-1:3], exp[2], exp[1:0]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i <= SY; i++) begin
            m_lk[i] = '0;
            m_bt[i] = 1'b1;
            m_sw[i] = 1'b0;
        end
        for (int i = 0; i < DEB; i++) m_obs[i] = 1'b1;
        m_deb   = 1'b1;
        m_rel   = 0;
        m_t     = 0;
        m_cause = 2'b00;
    endtask

    function automatic logic [EW-1:0] model_out();
        logic [NS-1:0] r;
        for (int i = 0; i < NS; i++) r[i] = (i >= m_rel) ? 1'b1 : 1'b0;
        return {r, (m_rel == NS) ? 1'b1 : 1'b0, m_cause};
    endfunction

    // Advance the model across one clock edge that samples the given inputs.
    task automatic model_step(input logic rst, input logic [NL-1:0] lk, input logic bt, input logic sw);
        logic lock_ok, sb, swr, pressed, fault, same;
        if (!rst) begin
            model_reset();
        end else begin
            lock_ok = &m_lk[SY-1];
            sb      = m_bt[SY-1];
            swr     = m_sw[SY-1] & ~m_sw[SY];
            pressed = ~m_deb;
            if (m_rel == 0) begin
                if (lock_ok && !pressed) begin
                    if (m_t == D - 1) begin
                        m_rel = 1;
                        m_t   = 0;
                    end else begin
                        m_t++;
                    end
                end else begin
                    m_t = 0;
                end
            end else begin
                fault = !lock_ok || pressed || (m_rel == NS && swr);
                if (fault) begin
                    m_cause = !lock_ok ? 2'b01 : (pressed ? 2'b10 : 2'b11);
                    m_rel   = 0;
                    m_t     = 0;
                end else if (m_rel < NS) begin
                    m_t++;
                    if (m_t == D) begin
                        m_rel++;
                        m_t = 0;
                    end
                end
            end
            // debounced level follows once the last DEB observations all agree
            for (int i = DEB - 1; i > 0; i--) m_obs[i] = m_obs[i-1];
            m_obs[0] = sb;
            same = 1'b1;
            for (int i = 0; i < DEB; i++) if (m_obs[i] != sb) same = 1'b0;
            if (same) m_deb = sb;
            for (int i = SY; i > 0; i--) begin
                m_lk[i] = m_lk[i-1];
                m_bt[i] = m_bt[i-1];
                m_sw[i] = m_sw[i-1];
            end
            m_lk[0] = lk;
            m_bt[0] = bt;
            m_sw[0] = sw;
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #2;
            reset_n_i     = cur_rst;
            locked_i      = cur_lk;
            btn_reset_n_i = cur_bt;
            sw_reset_i    = cur_sw;
            model_step(cur_rst, cur_lk, cur_bt, cur_sw);
            exp_q.push_back(model_out());
            if (!cur_rst) begin
                #1;
                check("async_reset", {reset_o, all_ready_o, cause_o}, {{NS{1'b1}}, 1'b0, 2'b00});
            end
        end
    endtask

    // Monitor: compare DUT outputs after each edge against the oldest queued expectation.
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("outputs", {reset_o, all_ready_o, cause_o}, e);
            end
        end
    end

    initial begin
        int r;
        int bt_low;
        cur_rst = 1'b0; cur_lk = '0; cur_bt = 1'b1; cur_sw = 1'b0;
        reset_n_i = 1'b0; locked_i = '0; btn_reset_n_i = 1'b1; sw_reset_i = 1'b0;
        model_reset();
        ticks(3);

        // power-on stagger
        cur_rst = 1'b1; cur_lk = '1;
        ticks(45);

        // one-cycle lock loss in RUN
        cur_lk[$urandom_range(0, NL-1)] = 1'b0;
        ticks(1);
        cur_lk = '1;
        ticks(45);

        // bouncing button settles high, then a genuine press
        for (int i = 0; i < 12; i++) begin
            cur_bt = ~cur_bt;
            ticks(5);
        end
        ticks(20);
        cur_bt = 1'b0;
        ticks(20 + $urandom_range(0, 10));
        cur_bt = 1'b1;
        ticks(60);

        // software request in RUN, then a request during STAGGER
        cur_sw = 1'b1;
        ticks(3);
        cur_sw = 1'b0;
        ticks(12 + $urandom_range(0, 4));
        cur_sw = 1'b1;
        ticks(2);
        cur_sw = 1'b0;
        ticks(45);

        // coincident lock loss and software request
        cur_lk[0] = 1'b0; cur_sw = 1'b1;
        ticks(1);
        cur_lk = '1;
        ticks(2);
        cur_sw = 1'b0;
        ticks(45);

        // power-on reset during STAGGER
        cur_lk[1] = 1'b0;
        ticks(1);
        cur_lk = '1;
        ticks($urandom_range(22, 26));
        cur_rst = 1'b0;
        ticks(2);
        cur_rst = 1'b1;
        ticks(45);

        // random traffic
        bt_low = 0;
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 999);
            cur_lk = '1;
            if (r < 4) cur_lk[$urandom_range(0, NL-1)] = 1'b0;
            if (bt_low == 0 && r >= 10 && r < 14) bt_low = $urandom_range(1, 40);
            cur_bt = (bt_low == 0) ? 1'b1 : (($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
            if (bt_low > 0) bt_low--;
            if (r >= 20 && r < 28) cur_sw = ~cur_sw;
            cur_rst = (r >= 997) ? 1'b0 : 1'b1;
            ticks(1);
        end
        cur_rst = 1'b1; cur_lk = '1; cur_bt = 1'b1; cur_sw = 1'b0;
        ticks(45);

        repeat (2) @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
